bottle_fill_sequencer: RTL and testbench
========================================

# bottle_fill_sequencer

Sequences the pill-bottling line for one production run: it indexes bottles in on the conveyor, opens the hopper gate, counts pills into each bottle, then ejects the filled bottle. It repeats until the target bottle count is reached. It sits between the operator setting/display logic, which supplies binary targets and start/ack pulses, and the line actuators and sensors. It owns all conveyor and gate control, fault detection (e-stop, jam, hopper starve) and the live pill/bottle counts that the display shows.

## Interface
Parameters:
- SETTLE_CYC, 50: cycles the conveyor stays stopped before the gate opens, and cycles the gate stays closed before eject.
- JAM_CYC, 3000: maximum cycles allowed in INDEX or EJECT.
- STARVE_CYC, 2000: maximum cycles in FILL without a pill_pulse.
- TIMER_W, 12: state-timer width; must hold max(JAM_CYC, STARVE_CYC).

Ports:
- clk_1khz  in  1  system clock, 1 kHz
- switch_clr  in  1  reset, asynchronous, active-low
- start  in  1  one-cycle pulse; begins a run
- ack  in  1  one-cycle pulse; acknowledges DONE or FAULT
- target_pills  in  10  pills per bottle, binary, 1..999
- target_bottles  in  7  bottles per run, binary, 1..99
- bottle_present  in  1  bottle at fill station; pre-synchronized level
- pill_pulse  in  1  one-cycle pulse per pill passing the gate sensor
- hopper_empty  in  1  hopper level sensor, level
- estop  in  1  emergency stop, active-high level
- conveyor_run  out  1  conveyor motor enable
- gate_open  out  1  hopper gate solenoid
- now_pills  out  10  pills in current bottle
- now_bottles  out  7  bottles completed
- state_code  out  3  current state encoding
- fault_code  out  2  0 none, 1 estop, 2 jam, 3 starve
- done  out  1  high in DONE

## Operation
State codes are IDLE=0, INDEX=1, SETTLE=2, FILL=3, DRAIN=4, EJECT=5, DONE=6, FAULT=7.

Transitions:
- **IDLE**: on start, latch targets, clear counters and fault_code, go to INDEX. Start is ignored if either target is 0.
- **INDEX**: conveyor_run=1. When bottle_present=1, go to SETTLE.
- **SETTLE**: after SETTLE_CYC cycles, go to FILL.
- **FILL**: gate_open=1. Each pill_pulse increments now_pills. The pulse that makes now_pills equal the latched target goes to DRAIN.
- **DRAIN**: after SETTLE_CYC cycles, go to EJECT.
- **EJECT**: conveyor_run=1. When bottle_present=0, increment now_bottles and clear now_pills. If the new now_bottles equals the latched target, go to DONE; otherwise go to INDEX.
- **DONE**: on ack, go to IDLE and clear counters. Start is ignored in DONE.
- **FAULT**: conveyor_run=0 and gate_open=0; counters hold their values. Ack with estop=0 goes to IDLE, clears counters and sets fault_code=0. Ack while estop=1 is ignored.

Fault entry, evaluated every cycle in INDEX..EJECT, first match wins:
- estop=1: fault_code 1.
- Timer reaches JAM_CYC in INDEX or EJECT: fault_code 2.
- hopper_empty=1, or timer reaches STARVE_CYC, in FILL: fault_code 3.

Fault entry overrides any concurrent transition. estop in IDLE or DONE is ignored, and estop blocks start in IDLE.

State timer:
- Clears on every state change and on every pill_pulse in FILL.
- Increments otherwise and saturates at all-ones.

Pill counting:
- pill_pulse outside FILL is ignored and not counted, including pulses during DRAIN.
- Latched targets are unaffected by input changes until the next accepted start.
- Counters are binary and never wrap: now_pills ≤ 999 and now_bottles ≤ 99 by construction.

## Timing
- All outputs are registered. Reset values: conveyor_run=0, gate_open=0, now_pills=0, now_bottles=0, state_code=0, fault_code=0, done=0.
- Assertion of switch_clr forces reset values immediately, asynchronously, in any state including mid-FILL.
- Outputs are Moore outputs: they change on the same edge as the state.
- A start sampled at edge N gives state_code=1 and conveyor_run=1 after edge N.
- The final pill_pulse sampled at edge N gives now_pills=target and gate_open=0 after edge N, so the gate closes with one cycle of latency.
- estop sampled at edge N gives FAULT with both actuators off after edge N.
- SETTLE and DRAIN each last exactly SETTLE_CYC cycles.
- A jam fault fires JAM_CYC cycles after state entry.

## Structure
- Shared package pill_line_pkg holds:
  - the state enum and its 3-bit encoding;
  - fault code constants;
  - the width constants PILL_W=10 and BOTTLE_W=7, which are also used by the setting/display logic.
- One sub-module, seq_timer: a clearable, saturating TIMER_W-bit up-counter with a `>= limit` compare output. It is instantiated once and shared by all timed states.

## Test plan
- **Reset**: drive switch_clr low for 3 cycles, then release → all outputs at reset values, state_code=0.
- **Nominal run**: targets 3/2, with a bottle model and 3 pill_pulses per fill → sequence 1,2,3,4,5 twice, then state_code=6, now_bottles=2, done=1. Ack → IDLE with counters 0.
- **Jam**: start with bottle_present held at 0 → after 3000 cycles, state_code=7 and fault_code=2. Ack → IDLE.
- **E-stop mid-FILL**: raise estop at now_pills=5 → next cycle FAULT, gate_open=0, now_pills stays 5. Ack with estop=1 is ignored. Ack after release → IDLE.
- **Starve and stray pills**: hopper_empty in FILL → fault_code=3. No pills for 2000 cycles → fault_code=3. pill_pulse during DRAIN → now_pills unchanged.
- **Boundaries**: targets 999/99 → reaches DONE with now_pills never exceeding 999. Start with target_pills=0 → stays in IDLE. Reset mid-FILL → outputs zero immediately.

Source files
------------

// File: rtl/pill_line_pkg.sv
// Shared definitions for the pill-bottling line: sequencer state encoding,
// fault codes and the counter widths also used by the setting/display logic.
package pill_line_pkg;

    localparam int unsigned PILL_W   = 10;
    localparam int unsigned BOTTLE_W = 7;

    // Encoding is visible on state_code, so the values are fixed.
    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StIndex  = 3'd1,
        StSettle = 3'd2,
        StFill   = 3'd3,
        StDrain  = 3'd4,
        StEject  = 3'd5,
        StDone   = 3'd6,
        StFault  = 3'd7
    } state_e;

    localparam logic [1:0] FaultNone   = 2'd0;
    localparam logic [1:0] FaultEstop  = 2'd1;
    localparam logic [1:0] FaultJam    = 2'd2;
    localparam logic [1:0] FaultStarve = 2'd3;

endpackage

// File: rtl/seq_timer.sv
// Clearable, saturating up-counter with a ">= limit" compare, shared by all
// timed sequencer states.
module seq_timer #(
    parameter int unsigned W = 12
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         clr_i,
    input  logic [W-1:0] limit_i,
    output logic         reached_o
);

    logic [W-1:0] count_q, count_d;

    // Next count: clear wins, otherwise count up and stick at all-ones.
    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (count_q != '1) begin
            count_d = count_q + W'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign reached_o = (count_q >= limit_i);

endmodule

// File: rtl/bottle_fill_sequencer.sv
// Production-run sequencer for the pill-bottling line: indexes bottles in,
// fills each with the target pill count, ejects it, and repeats until the
// target bottle count is reached. Detects e-stop, jam and hopper starve.
module bottle_fill_sequencer
    import pill_line_pkg::*;
#(
    parameter int unsigned SETTLE_CYC = 50,
    parameter int unsigned JAM_CYC    = 3000,
    parameter int unsigned STARVE_CYC = 2000,
    parameter int unsigned TIMER_W    = 12
) (
    input  logic                clk_1khz,
    input  logic                switch_clr,
    input  logic                start,
    input  logic                ack,
    input  logic [PILL_W-1:0]   target_pills,
    input  logic [BOTTLE_W-1:0] target_bottles,
    input  logic                bottle_present,
    input  logic                pill_pulse,
    input  logic                hopper_empty,
    input  logic                estop,
    output logic                conveyor_run,
    output logic                gate_open,
    output logic [PILL_W-1:0]   now_pills,
    output logic [BOTTLE_W-1:0] now_bottles,
    output logic [2:0]          state_code,
    output logic [1:0]          fault_code,
    output logic                done
);

    // The timer reads 0 in the first cycle of a state, so a limit of N-1
    // makes the state last exactly N cycles before the exit edge.
    localparam logic [TIMER_W-1:0] SettleLim = TIMER_W'(SETTLE_CYC - 1);
    localparam logic [TIMER_W-1:0] JamLim    = TIMER_W'(JAM_CYC - 1);
    localparam logic [TIMER_W-1:0] StarveLim = TIMER_W'(STARVE_CYC - 1);

    state_e              state_q, state_d;
    logic [PILL_W-1:0]   pills_q, pills_d, pills_inc;
    logic [BOTTLE_W-1:0] bottles_q, bottles_d, bottles_inc;
    logic [PILL_W-1:0]   tgt_pills_q, tgt_pills_d;
    logic [BOTTLE_W-1:0] tgt_bottles_q, tgt_bottles_d;
    logic [1:0]          fault_q, fault_d;
    logic                conveyor_q, conveyor_d;
    logic                gate_q, gate_d;
    logic                done_q, done_d;

    logic [TIMER_W-1:0]  timer_limit;
    logic                timer_clr;
    logic                timer_hit;

    assign pills_inc   = pills_q + PILL_W'(1);
    assign bottles_inc = bottles_q + BOTTLE_W'(1);

    seq_timer #(
        .W (TIMER_W)
    ) u_timer (
        .clk_i     (clk_1khz),
        .rst_ni    (switch_clr),
        .clr_i     (timer_clr),
        .limit_i   (timer_limit),
        .reached_o (timer_hit)
    );

    // Next-state, counter and Moore-output logic; fault entry takes priority.
    always_comb begin
        state_d       = state_q;
        pills_d       = pills_q;
        bottles_d     = bottles_q;
        tgt_pills_d   = tgt_pills_q;
        tgt_bottles_d = tgt_bottles_q;
        fault_d       = fault_q;
        timer_limit   = SettleLim;

        unique case (state_q)
            StIdle: begin
                if (start && !estop && (target_pills != '0) && (target_bottles != '0)) begin
                    tgt_pills_d   = target_pills;
                    tgt_bottles_d = target_bottles;
                    pills_d       = '0;
                    bottles_d     = '0;
                    fault_d       = FaultNone;
                    state_d       = StIndex;
                end
            end
            StIndex: begin
                timer_limit = JamLim;
                if (estop) begin
                    fault_d = FaultEstop;
                    state_d = StFault;
                end else if (timer_hit) begin
                    fault_d = FaultJam;
                    state_d = StFault;
                end else if (bottle_present) begin
                    state_d = StSettle;
                end
            end
            StSettle: begin
                if (estop) begin
                    fault_d = FaultEstop;
                    state_d = StFault;
                end else if (timer_hit) begin
                    state_d = StFill;
                end
            end
            StFill: begin
                timer_limit = StarveLim;
                if (estop) begin
                    fault_d = FaultEstop;
                    state_d = StFault;
                end else if (hopper_empty || timer_hit) begin
                    fault_d = FaultStarve;
                    state_d = StFault;
                end else if (pill_pulse) begin
                    pills_d = pills_inc;
                    if (pills_inc == tgt_pills_q) begin
                        state_d = StDrain;
                    end
                end
            end
            StDrain: begin
                if (estop) begin
                    fault_d = FaultEstop;
                    state_d = StFault;
                end else if (timer_hit) begin
                    state_d = StEject;
                end
            end
            StEject: begin
                timer_limit = JamLim;
                if (estop) begin
                    fault_d = FaultEstop;
                    state_d = StFault;
                end else if (timer_hit) begin
                    fault_d = FaultJam;
                    state_d = StFault;
                end else if (!bottle_present) begin
                    bottles_d = bottles_inc;
                    pills_d   = '0;
                    state_d   = (bottles_inc == tgt_bottles_q) ? StDone : StIndex;
                end
            end
            StDone: begin
                if (ack) begin
                    pills_d   = '0;
                    bottles_d = '0;
                    state_d   = StIdle;
                end
            end
            StFault: begin
                if (ack && !estop) begin
                    pills_d   = '0;
                    bottles_d = '0;
                    fault_d   = FaultNone;
                    state_d   = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // A pill restarts the starve window; any state change restarts timing.
        timer_clr  = (state_d != state_q) || ((state_q == StFill) && pill_pulse);

        // Outputs are decoded from the next state so they move with it.
        conveyor_d = (state_d == StIndex) || (state_d == StEject);
        gate_d     = (state_d == StFill);
        done_d     = (state_d == StDone);
    end

    // State, counter, latched-target and output registers.
    always_ff @(posedge clk_1khz or negedge switch_clr) begin
        if (!switch_clr) begin
            state_q       <= StIdle;
            pills_q       <= '0;
            bottles_q     <= '0;
            tgt_pills_q   <= '0;
            tgt_bottles_q <= '0;
            fault_q       <= FaultNone;
            conveyor_q    <= 1'b0;
            gate_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            pills_q       <= pills_d;
            bottles_q     <= bottles_d;
            tgt_pills_q   <= tgt_pills_d;
            tgt_bottles_q <= tgt_bottles_d;
            fault_q       <= fault_d;
            conveyor_q    <= conveyor_d;
            gate_q        <= gate_d;
            done_q        <= done_d;
        end
    end

    assign conveyor_run = conveyor_q;
    assign gate_open    = gate_q;
    assign now_pills    = pills_q;
    assign now_bottles  = bottles_q;
    assign state_code   = state_q;
    assign fault_code   = fault_q;
    assign done         = done_q;

endmodule

// File: tb/tb_bottle_fill_sequencer.sv
// Directed bench for bottle_fill_sequencer: nominal run, jam, e-stop, starve,
// stray pills, target boundaries and asynchronous reset.
module tb_bottle_fill_sequencer;

    localparam int SETTLE = 50;
    localparam int JAM    = 3000;
    localparam int STARVE = 2000;

    logic       clk_1khz;
    logic       switch_clr;
    logic       start;
    logic       ack;
    logic [9:0] target_pills;
    logic [6:0] target_bottles;
    logic       bottle_present;
    logic       pill_pulse;
    logic       hopper_empty;
    logic       estop;
    logic       conveyor_run;
    logic       gate_open;
    logic [9:0] now_pills;
    logic [6:0] now_bottles;
    logic [2:0] state_code;
    logic [1:0] fault_code;
    logic       done;

    int n_checks = 0;
    int n_fail   = 0;

    bottle_fill_sequencer #(
        .SETTLE_CYC (SETTLE),
        .JAM_CYC    (JAM),
        .STARVE_CYC (STARVE),
        .TIMER_W    (12)
    ) dut (
        .clk_1khz       (clk_1khz),
        .switch_clr     (switch_clr),
        .start          (start),
        .ack            (ack),
        .target_pills   (target_pills),
        .target_bottles (target_bottles),
        .bottle_present (bottle_present),
        .pill_pulse     (pill_pulse),
        .hopper_empty   (hopper_empty),
        .estop          (estop),
        .conveyor_run   (conveyor_run),
        .gate_open      (gate_open),
        .now_pills      (now_pills),
        .now_bottles    (now_bottles),
        .state_code     (state_code),
        .fault_code     (fault_code),
        .done           (done)
    );

    initial clk_1khz = 1'b0;
    always #5 clk_1khz = ~clk_1khz;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance one edge and sample just after it.
    task automatic tick();
        @(posedge clk_1khz);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic pulse_ack();
        ack = 1'b1;
        tick();
        ack = 1'b0;
    endtask

    // One bottle cycle starting in INDEX; ends after the eject edge.
    task automatic run_bottle(input int pills, input int exp_bottles, input bit last);
        check("bottle_index", 32'(state_code), 1);
        tick();
        bottle_present = 1'b1;
        tick();
        check("bottle_settle", 32'(state_code), 2);
        check("settle_conv_off", 32'(conveyor_run), 0);
        repeat (SETTLE - 1) tick();
        check("settle_hold", 32'(state_code), 2);
        tick();
        check("fill_entry", 32'(state_code), 3);
        check("fill_gate", 32'(gate_open), 1);
        for (int i = 1; i <= pills; i++) begin
            pill_pulse = 1'b1;
            tick();
            pill_pulse = 1'b0;
            check("fill_count", 32'(now_pills), 32'(i));
        end
        check("drain_entry", 32'(state_code), 4);
        check("drain_gate", 32'(gate_open), 0);
        pill_pulse = 1'b1;
        tick();
        pill_pulse = 1'b0;
        check("drain_stray", 32'(now_pills), 32'(pills));
        repeat (SETTLE - 2) tick();
        check("drain_hold", 32'(state_code), 4);
        tick();
        check("eject_entry", 32'(state_code), 5);
        check("eject_conv", 32'(conveyor_run), 1);
        tick();
        check("eject_wait", 32'(state_code), 5);
        bottle_present = 1'b0;
        tick();
        check("eject_bottles", 32'(now_bottles), 32'(exp_bottles));
        check("eject_pills", 32'(now_pills), 0);
        check("eject_next", 32'(state_code), last ? 6 : 1);
        check("eject_done", 32'(done), last ? 1 : 0);
    endtask

    // Enter FILL from IDLE with a bottle already at the station.
    task automatic go_to_fill();
        bottle_present = 1'b1;
        pulse_start();
        tick();
        repeat (SETTLE) tick();
        check("to_fill", 32'(state_code), 3);
    endtask

    initial begin
        switch_clr     = 1'b0;
        start          = 1'b0;
        ack            = 1'b0;
        target_pills   = 10'd3;
        target_bottles = 7'd2;
        bottle_present = 1'b0;
        pill_pulse     = 1'b0;
        hopper_empty   = 1'b0;
        estop          = 1'b0;

        // Reset
        repeat (3) tick();
        check("rst_state", 32'(state_code), 0);
        check("rst_pills", 32'(now_pills), 0);
        switch_clr = 1'b1;
        tick();
        check("rst_rel_state", 32'(state_code), 0);
        check("rst_conv", 32'(conveyor_run), 0);
        check("rst_gate", 32'(gate_open), 0);
        check("rst_bottles", 32'(now_bottles), 0);
        check("rst_fault", 32'(fault_code), 0);
        check("rst_done", 32'(done), 0);

        // Nominal 3/2; targets changed after start must not matter
        pulse_start();
        check("start_state", 32'(state_code), 1);
        check("start_conv", 32'(conveyor_run), 1);
        target_pills   = 10'd7;
        target_bottles = 7'd5;
        run_bottle(3, 1, 1'b0);
        run_bottle(3, 2, 1'b1);
        pulse_start();
        check("done_ignores_start", 32'(state_code), 6);
        pulse_ack();
        check("done_ack_state", 32'(state_code), 0);
        check("done_ack_bottles", 32'(now_bottles), 0);
        check("done_ack_done", 32'(done), 0);

        // Jam: no bottle arrives
        target_pills   = 10'd1;
        target_bottles = 7'd1;
        bottle_present = 1'b0;
        pulse_start();
        repeat (JAM - 1) tick();
        check("jam_hold", 32'(state_code), 1);
        tick();
        check("jam_state", 32'(state_code), 7);
        check("jam_code", 32'(fault_code), 2);
        check("jam_conv", 32'(conveyor_run), 0);
        pulse_ack();
        check("jam_ack", 32'(state_code), 0);
        check("jam_ack_code", 32'(fault_code), 0);

        // E-stop mid-FILL
        target_pills = 10'd10;
        go_to_fill();
        for (int i = 0; i < 5; i++) begin
            pill_pulse = 1'b1;
            tick();
        end
        pill_pulse = 1'b0;
        check("estop_pre_pills", 32'(now_pills), 5);
        estop = 1'b1;
        tick();
        check("estop_state", 32'(state_code), 7);
        check("estop_code", 32'(fault_code), 1);
        check("estop_gate", 32'(gate_open), 0);
        check("estop_pills", 32'(now_pills), 5);
        pulse_ack();
        check("estop_ack_held", 32'(state_code), 7);
        estop = 1'b0;
        tick();
        check("estop_released", 32'(state_code), 7);
        pulse_ack();
        check("estop_ack", 32'(state_code), 0);
        check("estop_ack_pills", 32'(now_pills), 0);
        check("estop_ack_code", 32'(fault_code), 0);

        // E-stop blocks start; zero target ignored
        estop = 1'b1;
        pulse_start();
        check("estop_blocks_start", 32'(state_code), 0);
        estop = 1'b0;
        target_pills = 10'd0;
        pulse_start();
        check("zero_target", 32'(state_code), 0);

        // Hopper empty in FILL
        target_pills = 10'd5;
        go_to_fill();
        hopper_empty = 1'b1;
        tick();
        hopper_empty = 1'b0;
        check("hopper_state", 32'(state_code), 7);
        check("hopper_code", 32'(fault_code), 3);
        pulse_ack();
        check("hopper_ack", 32'(state_code), 0);

        // Starve timeout, window restarted by a pill
        go_to_fill();
        pill_pulse = 1'b1;
        tick();
        pill_pulse = 1'b0;
        repeat (STARVE - 1) tick();
        check("starve_hold", 32'(state_code), 3);
        check("starve_pills", 32'(now_pills), 1);
        tick();
        check("starve_state", 32'(state_code), 7);
        check("starve_code", 32'(fault_code), 3);
        pulse_ack();
        check("starve_ack", 32'(state_code), 0);

        // Boundary: 999 pills in one bottle
        bottle_present = 1'b0;
        target_pills   = 10'd999;
        target_bottles = 7'd1;
        pulse_start();
        run_bottle(999, 1, 1'b1);
        pulse_ack();
        check("p999_ack", 32'(state_code), 0);

        // Boundary: 99 bottles of one pill
        target_pills   = 10'd1;
        target_bottles = 7'd99;
        pulse_start();
        for (int b = 1; b <= 99; b++) begin
            run_bottle(1, b, b == 99);
        end
        pulse_ack();
        check("b99_ack", 32'(state_code), 0);

        // Asynchronous reset mid-FILL
        target_pills   = 10'd5;
        target_bottles = 7'd1;
        go_to_fill();
        pill_pulse = 1'b1;
        repeat (2) tick();
        pill_pulse = 1'b0;
        check("mid_fill_pills", 32'(now_pills), 2);
        #2;
        switch_clr = 1'b0;
        #1;
        check("async_rst_state", 32'(state_code), 0);
        check("async_rst_gate", 32'(gate_open), 0);
        check("async_rst_pills", 32'(now_pills), 0);
        tick();
        switch_clr = 1'b1;
        tick();
        check("post_rst_state", 32'(state_code), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
